// File: rtl/apb_timer_arb.sv
// Round-robin APB master: shares one APB slave port among NREQ single-command
// requesters and aborts any ACCESS phase that waits TIMEOUT cycles for pready.
module apb_timer_arb #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_done,
    output logic               req_err,
    output logic [DW-1:0]      req_rdata,
    output logic               psel,
    output logic               penable,
    output logic [AW-1:0]      paddr,
    output logic               pwrite,
    output logic [DW-1:0]      pwdata,
    input  logic               pready,
    input  logic [DW-1:0]      prdata,
    output logic               busy
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;

    logic [AW-1:0]   addr_arr [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];
    logic [NREQ-1:0] eligible;
    logic            grant_found;
    logic [IW-1:0]   grant_idx, scan_idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*AW +: AW];
        assign wdata_arr[g] = req_wdata[g*DW +: DW];
    end

    // The requester whose done is pulsing is releasing valid this cycle.
    assign eligible = req_valid & ~done_q;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        scan_idx    = ptr_q;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = IW'((int'(ptr_q) + k) % NREQ);
            if (!grant_found && eligible[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        done_d    = '0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    ptr_d     = grant_idx;
                    paddr_d   = addr_arr[grant_idx];
                    pwdata_d  = wdata_arr[grant_idx];
                    pwrite_d  = req_write[grant_idx];
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready || cnt_q == CW'(TIMEOUT - 1)) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = NREQ'(1) << ptr_q;
                    err_d     = !pready;
                    if (!pready)
                        rdata_d = '0;
                    else if (!pwrite_q)
                        rdata_d = prdata;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(NREQ - 1);
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign req_rdata = rdata_q;
    assign req_done  = done_q;
    assign req_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_apb_timer_arb.sv
// Self-checking bench for apb_timer_arb: a 16-word APB slave with programmable
// wait states plus a round-robin/memory reference model kept in the bench.
module tb_apb_timer_arb;
    localparam int NREQ    = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic               pclk      = 1'b0;
    logic               presetn   = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_write = '0;
    logic [NREQ*AW-1:0] req_addr  = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_done;
    logic               req_err;
    logic [DW-1:0]      req_rdata;
    logic               psel, penable, pwrite, busy;
    logic [AW-1:0]      paddr;
    logic [DW-1:0]      pwdata;
    logic               pready = 1'b0;
    logic [DW-1:0]      prdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 pclk = ~pclk;

    apb_timer_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .busy(busy)
    );

    // ---------------- APB slave ----------------
    logic [DW-1:0] slv_mem [16];
    bit  mem_ready  = 1'b0;
    bit  stuck      = 1'b0;
    bit  rand_waits = 1'b0;
    int  cfg_waits  = 0;
    int  acc_cnt    = 0;
    int  cur_waits  = 0;
    int  acc_total  = 0;

    assign prdata = slv_mem[paddr[3:0]];

    always @(posedge pclk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
            mem_ready <= 1'b1;
        end else if (psel && penable && pready && pwrite) begin
            slv_mem[paddr[3:0]] <= pwdata;
        end
    end

    always @(negedge pclk) begin
        if (psel && penable) begin
            if (acc_cnt == 0) cur_waits = rand_waits ? int'($urandom_range(0, 3)) : cfg_waits;
            acc_cnt   = acc_cnt + 1;
            acc_total = acc_total + 1;
            pready    = !stuck && (acc_cnt > cur_waits);
        end else begin
            acc_cnt = 0;
            pready  = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [16];
    logic [DW-1:0] m_rdata;
    int            m_last;
    bit            c_wr   [NREQ];
    logic [AW-1:0] c_addr [NREQ];
    logic [DW-1:0] c_data [NREQ];

    function automatic int pick_next(int last, logic [NREQ-1:0] pend);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int oh2i(logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_complete(input int r, input bit err, output logic [DW-1:0] exp_rd);
        if (err)           m_rdata = '0;
        else if (!c_wr[r]) m_rdata = m_mem[c_addr[r][3:0]];
        else               m_mem[c_addr[r][3:0]] = c_data[r];
        m_last = r;
        exp_rd = m_rdata;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic post(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c_wr[r] = wr; c_addr[r] = a; c_data[r] = d;
        req_valid[r]           = 1'b1;
        req_write[r]           = wr;
        req_addr[r*AW +: AW]   = a;
        req_wdata[r*DW +: DW]  = d;
    endtask

    task automatic wait_done(output logic [NREQ-1:0] dv, output logic err,
                             output logic [DW-1:0] rd, output int cyc);
        dv = '0; err = 1'b0; rd = '0; cyc = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge pclk);
            if (req_done != '0) begin
                dv = req_done; err = req_err; rd = req_rdata; cyc = c;
                req_valid = req_valid & ~req_done;
                return;
            end
        end
        req_valid = '0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 50 && busy; c++) @(negedge pclk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_wait: busy=%b want 0", busy); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        presetn = 1'b0;
        repeat (3) @(negedge pclk);
        vectors += 9;
        if (psel      !== 1'b0) begin miscompares++; $display("FAIL rst_psel: got %b want 0", psel); end
        if (penable   !== 1'b0) begin miscompares++; $display("FAIL rst_penable: got %b want 0", penable); end
        if (pwrite    !== 1'b0) begin miscompares++; $display("FAIL rst_pwrite: got %b want 0", pwrite); end
        if (busy      !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (req_done  !== '0)   begin miscompares++; $display("FAIL rst_done: got %b want 0", req_done); end
        if (req_err   !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", req_err); end
        if (paddr     !== '0)   begin miscompares++; $display("FAIL rst_paddr: got %h want 0", paddr); end
        if (pwdata    !== '0)   begin miscompares++; $display("FAIL rst_pwdata: got %h want 0", pwdata); end
        if (req_rdata !== '0)   begin miscompares++; $display("FAIL rst_rdata: got %h want 0", req_rdata); end
        presetn = 1'b1;
        m_last  = NREQ - 1;
        m_rdata = '0;
        @(negedge pclk);
    endtask

    task automatic test_single_write();
        logic [DW-1:0] exp_rd;
        post(0, 1'b1, 32'h3, 32'd100);
        @(negedge pclk);
        vectors += 3;
        if (psel    !== 1'b1) begin miscompares++; $display("FAIL sw_setup_psel: got %b want 1", psel); end
        if (penable !== 1'b0) begin miscompares++; $display("FAIL sw_setup_penable: got %b want 0", penable); end
        if (busy    !== 1'b1) begin miscompares++; $display("FAIL sw_setup_busy: got %b want 1", busy); end
        @(negedge pclk);
        vectors += 4;
        if (penable !== 1'b1)   begin miscompares++; $display("FAIL sw_access_penable: got %b want 1", penable); end
        if (paddr   !== 32'h3)  begin miscompares++; $display("FAIL sw_paddr: got %h want 3", paddr); end
        if (pwdata  !== 32'd100) begin miscompares++; $display("FAIL sw_pwdata: got %0d want 100", pwdata); end
        if (pwrite  !== 1'b1)   begin miscompares++; $display("FAIL sw_pwrite: got %b want 1", pwrite); end
        @(negedge pclk);
        model_complete(0, 1'b0, exp_rd);
        vectors += 4;
        if (req_done  !== 3'b001) begin miscompares++; $display("FAIL sw_done: got %b want 001", req_done); end
        if (req_err   !== 1'b0)   begin miscompares++; $display("FAIL sw_err: got %b want 0", req_err); end
        if (psel      !== 1'b0)   begin miscompares++; $display("FAIL sw_psel_drop: got %b want 0", psel); end
        if (req_rdata !== exp_rd) begin miscompares++; $display("FAIL sw_rdata_hold: got %h want %h", req_rdata, exp_rd); end
        req_valid[0] = 1'b0;
        @(negedge pclk);
        vectors += 2;
        if (req_done !== '0) begin miscompares++; $display("FAIL sw_done_pulse: got %b want 0", req_done); end
        if (slv_mem[3] !== 32'd100) begin miscompares++; $display("FAIL sw_slave_reg: got %0d want 100", slv_mem[3]); end
    endtask

    task automatic test_read();
        logic [NREQ-1:0] dv; logic err; logic [DW-1:0] rd, exp_rd; int cyc;
        @(negedge pclk);
        post(1, 1'b1, 32'h2, 32'h187);
        wait_done(dv, err, rd, cyc);
        model_complete(1, 1'b0, exp_rd);
        vectors += 2;
        if (dv  !== 3'b010) begin miscompares++; $display("FAIL rd_wr_done: got %b want 010", dv); end
        if (err !== 1'b0)   begin miscompares++; $display("FAIL rd_wr_err: got %b want 0", err); end
        @(negedge pclk);
        post(1, 1'b0, 32'h2, 32'h0);
        wait_done(dv, err, rd, cyc);
        model_complete(1, 1'b0, exp_rd);
        vectors += 4;
        if (dv  !== 3'b010)  begin miscompares++; $display("FAIL rd_done: got %b want 010", dv); end
        if (err !== 1'b0)    begin miscompares++; $display("FAIL rd_err: got %b want 0", err); end
        if (rd  !== 32'h187) begin miscompares++; $display("FAIL rd_data: got %h want 187", rd); end
        if (rd  !== exp_rd)  begin miscompares++; $display("FAIL rd_model: got %h want %h", rd, exp_rd); end
    endtask

    task automatic test_contention();
        int got_q[$]; int when_q[$];
        logic [NREQ-1:0] repost = '0;
        logic [DW-1:0] exp_rd;
        int exp_r;
        @(negedge pclk);
        post(0, 1'b1, 32'h8, $urandom);
        post(1, 1'b1, 32'h9, $urandom);
        for (int c = 0; c < 60 && got_q.size() < 4; c++) begin
            @(negedge pclk);
            for (int r = 0; r < NREQ; r++) if (repost[r]) post(r, 1'b1, AW'(8 + r), $urandom);
            repost = '0;
            if (req_done != '0) begin
                exp_r = pick_next(m_last, 3'b011);
                got_q.push_back(oh2i(req_done));
                when_q.push_back(c);
                model_complete(exp_r, 1'b0, exp_rd);
                vectors += 3;
                if (req_done !== NREQ'(1) << exp_r) begin miscompares++; $display("FAIL ct_grant: got %b want req%0d", req_done, exp_r); end
                if (req_err !== 1'b0) begin miscompares++; $display("FAIL ct_err: got %b want 0", req_err); end
                if (req_rdata !== exp_rd) begin miscompares++; $display("FAIL ct_rdata: got %h want %h", req_rdata, exp_rd); end
                repost    = req_done;
                req_valid = req_valid & ~req_done;
                if (got_q.size() == 4) req_valid = '0;
            end
        end
        vectors++;
        if (got_q.size() != 4) begin miscompares++; $display("FAIL ct_count: got %0d want 4", got_q.size()); end
        for (int i = 1; i < when_q.size(); i++) begin
            vectors++;
            if (when_q[i] - when_q[i-1] != 3) begin
                miscompares++; $display("FAIL ct_spacing: got %0d want 3", when_q[i] - when_q[i-1]);
            end
        end
        wait_idle();
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] exp_rd;
        int acc = 0;
        bit in_access = 1'b0;
        bit seen = 1'b0;
        cfg_waits = 5;
        @(negedge pclk);
        post(1, 1'b0, 32'h2, 32'h0);
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge pclk);
            if (req_done != '0) begin
                seen = 1'b1;
                model_complete(1, 1'b0, exp_rd);
                vectors += 4;
                if (req_done  !== 3'b010) begin miscompares++; $display("FAIL ws_done: got %b want 010", req_done); end
                if (req_err   !== 1'b0)   begin miscompares++; $display("FAIL ws_err: got %b want 0", req_err); end
                if (req_rdata !== exp_rd) begin miscompares++; $display("FAIL ws_rdata: got %h want %h", req_rdata, exp_rd); end
                if (acc != 6) begin miscompares++; $display("FAIL ws_access_cycles: got %0d want 6", acc); end
                req_valid[1] = 1'b0;
            end else if (psel) begin
                if (penable) in_access = 1'b1;
                if (in_access) acc++;
                vectors += 3;
                if (paddr  !== 32'h2) begin miscompares++; $display("FAIL ws_paddr: got %h want 2", paddr); end
                if (pwrite !== 1'b0)  begin miscompares++; $display("FAIL ws_pwrite: got %b want 0", pwrite); end
                if (penable !== in_access) begin miscompares++; $display("FAIL ws_penable: got %b want %b", penable, in_access); end
            end else if (in_access) begin
                vectors++; miscompares++;
                $display("FAIL ws_psel_stable: got psel=0 want 1 during access");
            end
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL ws_timeout: got no done want done"); end
        req_valid = '0;
        cfg_waits = 0;
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] dv; logic err; logic [DW-1:0] rd, exp_rd, wd; int cyc, a0;
        stuck = 1'b1;
        a0 = acc_total;
        @(negedge pclk);
        post(0, 1'b0, 32'h2, 32'h0);
        wait_done(dv, err, rd, cyc);
        model_complete(0, 1'b1, exp_rd);
        vectors += 4;
        if (dv  !== 3'b001) begin miscompares++; $display("FAIL to_done: got %b want 001", dv); end
        if (err !== 1'b1)   begin miscompares++; $display("FAIL to_err: got %b want 1", err); end
        if (rd  !== '0)     begin miscompares++; $display("FAIL to_rdata: got %h want 0", rd); end
        if (acc_total - a0 != TIMEOUT) begin
            miscompares++; $display("FAIL to_access_cycles: got %0d want %0d", acc_total - a0, TIMEOUT);
        end
        stuck = 1'b0;
        wd = $urandom;
        @(negedge pclk);
        post(2, 1'b1, 32'h5, wd);
        wait_done(dv, err, rd, cyc);
        model_complete(2, 1'b0, exp_rd);
        @(negedge pclk);
        post(2, 1'b0, 32'h5, 32'h0);
        wait_done(dv, err, rd, cyc);
        model_complete(2, 1'b0, exp_rd);
        vectors += 3;
        if (dv  !== 3'b100) begin miscompares++; $display("FAIL to_next_done: got %b want 100", dv); end
        if (err !== 1'b0)   begin miscompares++; $display("FAIL to_next_err: got %b want 0", err); end
        if (rd  !== wd)     begin miscompares++; $display("FAIL to_next_rdata: got %h want %h", rd, wd); end
    endtask

    task automatic test_reset_in_access();
        logic [NREQ-1:0] dv, pend; logic err; logic [DW-1:0] rd, exp_rd; int cyc, exp_r;
        stuck = 1'b1;
        @(negedge pclk);
        post(0, 1'b0, 32'h3, 32'h0);
        for (int c = 0; c < 10 && !penable; c++) @(negedge pclk);
        repeat (3) @(negedge pclk);
        vectors++;
        if (penable !== 1'b1) begin miscompares++; $display("FAIL ra_in_access: got %b want 1", penable); end
        presetn = 1'b0;
        #1;
        vectors += 4;
        if (psel     !== 1'b0) begin miscompares++; $display("FAIL ra_psel: got %b want 0", psel); end
        if (penable  !== 1'b0) begin miscompares++; $display("FAIL ra_penable: got %b want 0", penable); end
        if (busy     !== 1'b0) begin miscompares++; $display("FAIL ra_busy: got %b want 0", busy); end
        if (req_done !== '0)   begin miscompares++; $display("FAIL ra_done: got %b want 0", req_done); end
        req_valid = '0;
        stuck     = 1'b0;
        m_last    = NREQ - 1;
        m_rdata   = '0;
        @(negedge pclk);
        presetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge pclk);
            vectors++;
            if (req_done !== '0) begin miscompares++; $display("FAIL ra_no_done: got %b want 0", req_done); end
        end
        for (int r = 0; r < NREQ; r++) post(r, $urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom);
        pend = '1;
        for (int n = 0; n < NREQ; n++) begin
            wait_done(dv, err, rd, cyc);
            exp_r = pick_next(m_last, pend);
            pend[exp_r] = 1'b0;
            model_complete(exp_r, 1'b0, exp_rd);
            vectors += 2;
            if (dv !== NREQ'(1) << exp_r) begin miscompares++; $display("FAIL ra_grant: got %b want req%0d", dv, exp_r); end
            if (rd !== exp_rd) begin miscompares++; $display("FAIL ra_rdata: got %h want %h", rd, exp_rd); end
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] dv, pend; logic err; logic [DW-1:0] rd, exp_rd; int cyc, exp_r;
        rand_waits = 1'b1;
        for (int b = 0; b < 15; b++) begin
            wait_idle();
            @(negedge pclk);
            pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int r = 0; r < NREQ; r++)
                if (pend[r]) post(r, $urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom);
            while (pend != '0) begin
                wait_done(dv, err, rd, cyc);
                exp_r = pick_next(m_last, pend);
                pend[exp_r] = 1'b0;
                model_complete(exp_r, 1'b0, exp_rd);
                vectors += 3;
                if (dv  !== NREQ'(1) << exp_r) begin miscompares++; $display("FAIL rnd_grant: got %b want req%0d", dv, exp_r); end
                if (err !== 1'b0)   begin miscompares++; $display("FAIL rnd_err: got %b want 0", err); end
                if (rd  !== exp_rd) begin miscompares++; $display("FAIL rnd_rdata: got %h want %h", rd, exp_rd); end
                if (cyc < 0) pend = '0;
            end
        end
        rand_waits = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        for (int r = 0; r < NREQ; r++) begin c_wr[r] = 1'b0; c_addr[r] = '0; c_data[r] = '0; end
        m_last  = NREQ - 1;
        m_rdata = '0;
        test_reset();
        test_single_write();
        test_read();
        test_contention();
        test_wait_states();
        test_timeout();
        test_reset_in_access();
        test_random();
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/apb_timer_arb.md
Name: apb_timer_arb

Overview:
- Round-robin APB master that shares the single timerapb slave port among NREQ on-chip requesters (CPU config port, DMA reload, irq service engine).
- Each requester posts a single read/write command. The block arbitrates, runs the APB SETUP/ACCESS sequence, and returns completion, read data and error.
- A watchdog aborts transfers when the slave never asserts pready.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, APB address width.
- DW, 32, APB data width.
- TIMEOUT, 16, max ACCESS cycles without pready before abort (>=2).

Ports:
- pclk  input  1  clock; all logic on rising edge.
- presetn  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester command valid; held until its req_done.
- req_write  input  NREQ  per-requester 1=write, 0=read.
- req_addr  input  NREQ*AW  flattened addresses; requester i at [i*AW +: AW].
- req_wdata  input  NREQ*DW  flattened write data.
- req_done  output  NREQ  one-hot, one-cycle completion pulse.
- req_err  output  1  valid with req_done; 1 = timeout abort.
- req_rdata  output  DW  read data, valid with req_done for reads.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- paddr  output  AW  APB address.
- pwrite  output  1  APB direction.
- pwdata  output  DW  APB write data.
- pready  input  1  slave ready.
- prdata  input  DW  slave read data.
- busy  output  1  high in SETUP or ACCESS.

Behaviour:
- Reset: async on presetn low. State=IDLE; psel, penable, pwrite, busy, req_done, req_err=0; paddr, pwdata, req_rdata=0; rr pointer=NREQ-1 (requester 0 has first priority).
- All outputs are registered.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from pointer+1 modulo NREQ.
  - Latch that requester's addr, wdata and write into paddr/pwdata/pwrite; psel<=1; penable<=0; pointer<=winner; go to SETUP.
  - If no req_valid is set, hold.
- SETUP: exactly 1 cycle. penable<=1; clear timeout counter; go to ACCESS.
- ACCESS, per cycle with psel=penable=1:
  - pready=1: psel<=0, penable<=0. req_done[winner]<=1, req_err<=0; for a read, req_rdata<=prdata (for a write, req_rdata holds). Go to IDLE.
  - pready=0 and counter==TIMEOUT-1: same deassert; req_done[winner]<=1, req_err<=1, req_rdata<=0. Go to IDLE.
  - Otherwise: counter+1.
- req_done and req_err are high for exactly 1 cycle, the first IDLE cycle after completion.
- Arbitration in that same IDLE cycle ignores the winner's req_valid bit, since the requester is dropping it. A new command from that requester is accepted from the next cycle.
- Minimum transfer period is 3 cycles (IDLE, SETUP, ACCESS). Back-to-back zero-wait transfers therefore issue one every 3 cycles.
- paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS; they hold their last value in IDLE.
- If a requester drops req_valid during SETUP or ACCESS, the transfer still completes and req_done still pulses.
- Fairness: with all NREQ requesting continuously, each is served once per NREQ transfers.
- busy = (state != IDLE).
- Reset mid-transfer aborts immediately to the reset values. No req_done is issued for the aborted transfer.

Test Plan:
- Single write: req0 write addr 0x3 data 100 with pready tied 1. Expect psel rising 1 cycle after req_valid, penable 1 cycle later, then req_done[0] pulse; slave load register reads 100.
- Read: req1 read addr 0x2 after writing 0x187 there. Expect req_done[1]=1, req_err=0, req_rdata=0x187.
- Contention: req0 and req1 assert in the same cycle, both continuous, 4 transfers. Grant order 0,1,0,1; req_done spaced 3 cycles apart.
- Wait states: slave holds pready=0 for 5 ACCESS cycles. Expect psel/penable/paddr stable throughout, then req_done 1 cycle after pready, err=0.
- Timeout: pready stuck 0 with TIMEOUT=16. Expect exactly 16 ACCESS cycles, then req_done with req_err=1 and req_rdata=0; the next request proceeds normally.
- Reset in ACCESS: drop presetn. Expect psel=penable=busy=0 immediately and no req_done; after release, requester 0 has first priority.
